mbc_seq_alu: RTL
================

Name: mbc_seq_alu

Overview:
Parametrised, registered successor to the combinational basic-computer ALU. It owns the accumulator (AC), the E flip-flop and a new high-result register (HR), and executes one operation per accepted request. It adds SUB, OR and XOR, a zero flag, and a multi-cycle unsigned shift-add multiply behind a valid/ready/done handshake. It sits between the control sequencer and the DR/bus datapath.

Parameters:
WIDTH, 16, datapath width of AC/DR/HR; legal range 4..32
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as illegal and no multiplier logic is built

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
op_valid  in  1  request present
op_ready  out  1  unit can accept; equals !busy
code  in  4  opcode, sampled on acceptance
dr_in  in  WIDTH  DR operand, sampled on acceptance
ac_out  out  WIDTH  AC register
e_out  out  1  E flip-flop
hr_out  out  WIDTH  high half of the last MUL result
ac_zero  out  1  (ac_out == 0), decoded from the register
busy  out  1  multiply in progress
done  out  1  one-cycle pulse on completion of every accepted op
err  out  1  one-cycle pulse, coincident with done, for an illegal opcode

Behaviour:
- Reset values: AC=0, E=0, HR=0, busy=0, done=0, err=0, FSM=IDLE; ac_zero=1, op_ready=1.
- Acceptance: op_valid && op_ready at a rising edge. While busy, op_valid is ignored and no state changes.
- Opcodes (AC, DR, E refer to pre-edge values):
  - 0000 AND: AC<=AC&DR.
  - 0001 ADD: {E,AC}<=AC+DR, with the carry into E.
  - 0010 LDA: AC<=DR.
  - 0011 CMA: AC<=~AC.
  - 0100 CIR: AC<={E,AC[W-1:1]}, E<=AC[0].
  - 0101 CIL: AC<={AC[W-2:0],E}, E<=AC[W-1].
  - 0110 CLA: AC<=0.
  - 0111 CLE: E<=0.
  - 1000 CME: E<=~E.
  - 1001 INC: AC<=AC+1 (wraps), E unchanged.
  - 1010 SUB: {E,AC}<=AC+~DR+1, so E=1 means no borrow.
  - 1011 OR.
  - 1100 MUL.
  - 1101 XOR.
  - 1110 and 1111 are illegal.
  - Anything not listed is left unchanged.
- Single-cycle ops: result is registered at the accepting edge. done is high for exactly the following cycle. Back-to-back acceptance every cycle is allowed.
- Illegal opcode (including MUL when MUL_EN=0): no register changes; done=1 and err=1 for one cycle.
- MUL FSM, states IDLE and MUL:
  - On acceptance at edge k: capture multiplicand=AC, multiplier=DR and partial=0 into internal working registers, set counter=WIDTH, enter MUL, busy<=1.
  - One shift-add iteration per edge, edges k+1..k+WIDTH.
  - AC, E and HR remain unchanged during iteration.
  - At edge k+WIDTH: {HR,AC}<=AC*DR (unsigned, 2*WIDTH bits) and E<=(HR_new!=0) as the overflow indicator. busy<=0, return to IDLE, done pulses the next cycle.
  - Latency from acceptance to done: WIDTH+1 cycles.
  - op_ready rises in the same cycle as done, so a new op may be accepted at that edge.
- HR is written only by MUL; all other ops leave it unchanged.
- rst asserted in any state, including mid-MUL, returns everything to reset values at that edge; no done is produced for an aborted op.
- Arithmetic is modulo 2^WIDTH, with carry/borrow captured only in E as specified above.

Decomposition:
- Shared package mbc_alu_pkg holds:
  - 4-bit opcode localparams OP_AND..OP_XOR;
  - FSM state encoding (IDLE, MUL);
  - a legality function op_is_legal(code, MUL_EN).
- Natural sub-module: mbc_shift_add_mul, the WIDTH-parametrised iterative multiplier with start/busy/done. It is instantiated only when MUL_EN=1; the top level holds the AC/E/HR registers, decode and the single-cycle ops.

Test Plan (WIDTH=16, MUL_EN=1 unless stated):
- Reset, then LDA DR=0xFFFF, then ADD DR=0x0001 -> AC=0x0000, E=1, ac_zero=1; done pulses 1 cycle after each accepting edge.
- LDA 0x0001, CLE, CIR -> AC=0x0000, E=1; then CIL -> AC=0x0001, E=0. Then SUB DR=0x0002 -> AC=0xFFFF, E=0.
- LDA 0x0100, then MUL DR=0x0300 -> busy high 16 cycles, AC unchanged meanwhile. done in cycle 17 after acceptance, with HR=0x0003, AC=0x0000, E=1. MUL 0x0003×0x0005 -> HR=0, AC=0x000F, E=0.
- While busy, pulse op_valid with CLA -> ignored; AC equals the MUL result afterwards, and exactly one done is produced.
- Assert rst 5 cycles into a MUL -> next cycle AC=HR=0, E=0, busy=0, no done. code=1110 -> err=done=1 for one cycle, state unchanged.
- MUL_EN=0, code=1100 -> err pulse, no busy, AC unchanged. Back-to-back INC×3 on consecutive cycles from AC=0xFFFE -> 0xFFFF, 0x0000, 0x0001, with E untouched.

Source files
------------

// File: rtl/mbc_alu_pkg.sv
// Shared definitions for the registered basic-computer ALU: opcodes, FSM states
// and opcode legality.
package mbc_alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LDA = 4'b0010;
  localparam logic [3:0] OP_CMA = 4'b0011;
  localparam logic [3:0] OP_CIR = 4'b0100;
  localparam logic [3:0] OP_CIL = 4'b0101;
  localparam logic [3:0] OP_CLA = 4'b0110;
  localparam logic [3:0] OP_CLE = 4'b0111;
  localparam logic [3:0] OP_CME = 4'b1000;
  localparam logic [3:0] OP_INC = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  // MUL is only legal when the multiplier is built.
  function automatic logic op_is_legal(input logic [3:0] code, input bit mul_en);
    logic legal;
    legal = (code <= OP_XOR);
    if ((code == OP_MUL) && !mul_en) legal = 1'b0;
    return legal;
  endfunction

endpackage

// File: rtl/mbc_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial-product step per clock,
// WIDTH steps per product.
module mbc_shift_add_mul #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic                 busy;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   partial;
  logic [WIDTH-1:0]     mplier;

  // done/product describe the step taken at the coming edge, so the owner can
  // latch the finished product on the same edge as the last iteration.
  always_comb begin
    product = partial + (mplier[0] ? mcand : '0);
    done    = busy && (count == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      count   <= '0;
      mcand   <= '0;
      partial <= '0;
      mplier  <= '0;
    end else if (start && !busy) begin
      busy    <= 1'b1;
      count   <= CW'(WIDTH);
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      partial <= '0;
    end else if (busy) begin
      partial <= product;
      mcand   <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier  <= {1'b0, mplier[WIDTH-1:1]};
      count   <= count - CW'(1);
      if (count == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mbc_seq_alu.sv
// Registered basic-computer ALU owning AC, E and HR; single-cycle ops plus an
// optional multi-cycle unsigned multiply behind a valid/ready/done handshake.
module mbc_seq_alu
  import mbc_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       code,
  input  logic [WIDTH-1:0] dr_in,
  output logic [WIDTH-1:0] ac_out,
  output logic             e_out,
  output logic [WIDTH-1:0] hr_out,
  output logic             ac_zero,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};

  state_t               state;
  logic                 accept;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;

  always_comb begin
    busy     = (state == ST_MUL);
    op_ready = !busy;
    ac_zero  = (ac_out == '0);
    accept   = op_valid && op_ready;
  end

  generate
    if (MUL_EN) begin : g_mul
      mbc_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && (code == OP_MUL)),
        .a       (ac_out),
        .b       (dr_in),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_nomul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ac_out <= '0;
      e_out  <= 1'b0;
      hr_out <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!op_is_legal(code, MUL_EN)) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (code == OP_MUL) begin
              state <= ST_MUL;
            end else begin
              done <= 1'b1;
              case (code)
                OP_AND: ac_out <= ac_out & dr_in;
                OP_ADD: {e_out, ac_out} <= {1'b0, ac_out} + {1'b0, dr_in};
                OP_LDA: ac_out <= dr_in;
                OP_CMA: ac_out <= ~ac_out;
                OP_CIR: begin
                  ac_out <= {e_out, ac_out[WIDTH-1:1]};
                  e_out  <= ac_out[0];
                end
                OP_CIL: begin
                  ac_out <= {ac_out[WIDTH-2:0], e_out};
                  e_out  <= ac_out[WIDTH-1];
                end
                OP_CLA: ac_out <= '0;
                OP_CLE: e_out  <= 1'b0;
                OP_CME: e_out  <= ~e_out;
                OP_INC: ac_out <= ac_out + ONE;
                // E ends up as the inverted borrow: 1 means AC >= DR.
                OP_SUB: {e_out, ac_out} <= {1'b0, ac_out} + {1'b0, ~dr_in} + ONE_X;
                OP_OR:  ac_out <= ac_out | dr_in;
                OP_XOR: ac_out <= ac_out ^ dr_in;
                default: ;
              endcase
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            {hr_out, ac_out} <= mul_prod;
            e_out            <= |mul_prod[2*WIDTH-1:WIDTH];
            state            <= ST_IDLE;
            done             <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
